fifo_rd_fwft: RTL and testbench

Read-domain controller for the CDC asynchronous FIFO, directly downstream of the write-pointer block. It owns the binary read pointer and compares it against the write pointer already brought into the read domain. It raises empty, drives the memory read address and clock enable, and presents data first-word-fall-through through a 2-entry output buffer with a valid/ready handshake. Its `rptr` is the value that the write side synchronizes and compares as `w_rptr`.

---
 rtl/fifo_rd_fwft_pkg.sv | 9 +
 rtl/fifo_out_buf.sv | 41 ++++
 rtl/fifo_rd_fwft.sv | 60 ++++++
 tb/tb_fifo_rd_fwft.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_fwft_pkg.sv
// Shared constants for the read side of the CDC FIFO (also used by the
// write side and the memory): pointer/data widths and output buffer depth.
package fifo_rd_fwft_pkg;
  localparam int RPTR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int BUF_DEPTH  = 2;

  typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output register buffer. Head is always entry 0, so dout is a
// plain register with no path from din.
module fifo_out_buf
  import fifo_rd_fwft_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output occ_t          cnt,
  output logic [DW-1:0] dout,
  output logic          dout_valid
);

  logic [DW-1:0] tail;
  occ_t          lvl;

  // occupancy after this cycle's pop; picks the slot an incoming word lands in
  assign lvl        = cnt - occ_t'(pop);
  assign dout_valid = (cnt != 2'd0);

  // shift tail into head on pop, write the new word at the first free slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      dout <= '0;
      tail <= '0;
    end else begin
      cnt <= cnt + occ_t'(push) - occ_t'(pop);
      if (pop && cnt == 2'd2) dout <= tail;
      if (push) begin
        if (lvl == 2'd0) dout <= din;
        else             tail <= din;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-domain controller: binary read pointer, empty compare against the
// synchronized write pointer, memory fetch with credit-based flow control,
// and a first-word-fall-through output through a 2-entry buffer.
module fifo_rd_fwft
  import fifo_rd_fwft_pkg::*;
#(
  parameter int PTR_WIDTH  = RPTR_WIDTH,
  parameter int DATA_WIDTH = fifo_rd_fwft_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PTR_WIDTH-1:0]  r_wptr,
  output logic [PTR_WIDTH-1:0]  rptr,
  output logic [PTR_WIDTH-2:0]  r_raddr,
  output logic                  rclken,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  output logic                  rempty,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  logic       inflight;
  logic       pop;
  occ_t       cnt;
  logic [2:0] credit_lvl;

  assign rempty  = (rptr == r_wptr);
  assign r_raddr = rptr[PTR_WIDTH-2:0];
  assign pop     = dout_valid & dout_ready;

  // words that will occupy the buffer once the in-flight read lands and
  // this cycle's pop retires; a fetch is allowed only if a slot stays free
  assign credit_lvl = 3'(cnt) + 3'(inflight) - 3'(pop);
  // rst gating keeps the memory idle while reset is held with data present
  assign rclken     = rst & ~rempty & (credit_lvl < 3'(BUF_DEPTH));

  // pointer advance and one-cycle memory read latency tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      if (rclken) rptr <= rptr + PTR_WIDTH'(1);
      inflight <= rclken;
    end
  end

  fifo_out_buf #(.DW(DATA_WIDTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight),
    .din        (rdata_mem),
    .pop        (pop),
    .cnt        (cnt),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: directed timeline table, async reset mid-burst,
// streaming, and a randomized wrap run against a queue scoreboard.
module tb_fifo_rd_fwft;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] r_wptr = '0;
  logic [3:0] rptr;
  logic [2:0] r_raddr;
  logic       rclken;
  logic [7:0] rdata_mem = '0;
  logic       rempty;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;

  logic [7:0] mem [8];

  int vectors = 0;
  int miscompares = 0;

  fifo_rd_fwft #(.PTR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .r_wptr     (r_wptr),
    .rptr       (rptr),
    .r_raddr    (r_raddr),
    .rclken     (rclken),
    .rdata_mem  (rdata_mem),
    .rempty     (rempty),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  // memory model: registered read, data valid the cycle after rclken
  always @(posedge clk) if (rclken) rdata_mem <= mem[r_raddr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] wptr;
    logic       rdy;
    logic       e_rempty;
    logic       e_rclken;
    logic       e_dv;
    logic [7:0] e_dout;
    logic       chk_dout;
    logic [3:0] e_rptr;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [14:0] act, exp;
    logic [7:0]  q[$];
    logic [3:0]  wp, used;
    logic [7:0]  nextv, hold_dout;
    logic        hold;
    int          written, wraps;
    bit          done;

    // timeline from reset: single word, backpressure on 5 more, drain
    //          wptr rdy  emp clk dv  dout   chk rptr
    tbl[0]  = '{4'd0, 0, 1, 0, 0, 8'h00, 1, 4'd0};
    tbl[1]  = '{4'd1, 0, 0, 1, 0, 8'h00, 1, 4'd0};
    tbl[2]  = '{4'd1, 0, 1, 0, 0, 8'h00, 1, 4'd1};
    tbl[3]  = '{4'd1, 0, 1, 0, 1, 8'hA5, 1, 4'd1};
    tbl[4]  = '{4'd6, 0, 0, 1, 1, 8'hA5, 1, 4'd1};
    tbl[5]  = '{4'd6, 0, 0, 0, 1, 8'hA5, 1, 4'd2};
    tbl[6]  = '{4'd6, 0, 0, 0, 1, 8'hA5, 1, 4'd2};
    tbl[7]  = '{4'd6, 1, 0, 1, 1, 8'hA5, 1, 4'd2};
    tbl[8]  = '{4'd6, 1, 0, 1, 1, 8'h11, 1, 4'd3};
    tbl[9]  = '{4'd6, 1, 0, 1, 1, 8'h22, 1, 4'd4};
    tbl[10] = '{4'd6, 1, 0, 1, 1, 8'h33, 1, 4'd5};
    tbl[11] = '{4'd6, 1, 1, 0, 1, 8'h44, 1, 4'd6};
    tbl[12] = '{4'd6, 0, 1, 0, 1, 8'h55, 1, 4'd6};
    tbl[13] = '{4'd6, 1, 1, 0, 1, 8'h55, 1, 4'd6};
    tbl[14] = '{4'd6, 1, 1, 0, 0, 8'h00, 0, 4'd6};

    mem[0] = 8'hA5; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
    mem[4] = 8'h44; mem[5] = 8'h55; mem[6] = 8'h66; mem[7] = 8'h77;

    // reset state
    #3;
    chk("reset_state", {rptr, dout_valid, dout, rclken, rempty}, {4'd0, 1'b0, 8'h00, 1'b0, 1'b1});
    step();
    rst = 1'b1;

    // directed timeline
    for (int i = 0; i < 15; i++) begin
      r_wptr     = tbl[i].wptr;
      dout_ready = tbl[i].rdy;
      @(negedge clk);
      act = {rempty, rclken, dout_valid, tbl[i].chk_dout ? dout : 8'h00, rptr};
      exp = {tbl[i].e_rempty, tbl[i].e_rclken, tbl[i].e_dv, tbl[i].e_dout, tbl[i].e_rptr};
      chk($sformatf("table_row%0d", i), 32'(act), 32'(exp));
      step();
    end

    // fill the buffer with 8 words available, then reset asynchronously
    r_wptr = 4'd14; dout_ready = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chk("pre_reset_full", {dout_valid, rclken}, 2'b10);
    #1 rst = 1'b0;
    #1 chk("async_reset", {rptr, dout_valid, dout, rclken, rempty}, {4'd0, 1'b0, 8'h00, 1'b0, 1'b0});
    r_wptr = 4'd0;
    #1 chk("reset_empty_follow", rempty, 1'b1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset", {rempty, dout_valid, rptr}, {1'b1, 1'b0, 4'd0});
    step();

    // streaming 8 words with ready held high
    for (int k = 0; k < 8; k++) mem[k] = 8'(k + 1);
    r_wptr = 4'd8; dout_ready = 1'b1;
    @(negedge clk);
    chk("stream_fetch_T", rclken, 1'b1);
    step();
    @(negedge clk);
    chk("stream_T1_novalid", dout_valid, 1'b0);
    step();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("stream_beat%0d", k), {dout_valid, dout}, {1'b1, 8'(k + 1)});
      step();
    end
    @(negedge clk);
    chk("stream_end", {dout_valid, rptr, rempty}, {1'b0, 4'd8, 1'b1});
    step();

    // random wrap run: scoreboard queue of written words
    wp = 4'd8; written = 0; wraps = 0; nextv = 8'h40; hold = 1'b0; hold_dout = '0;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      used = wp - rptr;
      if (written < 40 && $urandom_range(9) < 6 && used < 4'd8) begin
        mem[wp[2:0]] = nextv;
        q.push_back(nextv);
        nextv = nextv + 8'd3;
        wp = wp + 4'd1;
        written++;
      end
      r_wptr     = wp;
      dout_ready = ($urandom_range(9) < 7);
      @(negedge clk);
      if (rempty != (rptr == r_wptr)) chk("rempty_rule", rempty, rptr == r_wptr);
      if (rempty && rclken) chk("rclken_while_empty", rclken, 1'b0);
      if (r_raddr != rptr[2:0]) chk("raddr_rule", r_raddr, rptr[2:0]);
      if (hold) chk("hold_stable", {dout_valid, dout}, {1'b1, hold_dout});
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) chk("beat_extra", 1, 0);
        else chk("beat_data", dout, q.pop_front());
      end
      if (rclken && r_raddr == 3'd7) wraps++;
      hold = dout_valid & ~dout_ready;
      hold_dout = dout;
      done = (written == 40) && (q.size() == 0);
      step();
    end
    chk("scoreboard_drained", q.size(), 0);
    chk("wrap_count", (wraps >= 4), 1);
    @(negedge clk);
    chk("final_empty", {rempty, dout_valid}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
